// File: rtl/door_servo_ctrl.sv
// -----------------------------------------------------------------------------
// door_servo_ctrl
//   Elevator door controller driving one hobby-servo PWM line per floor.
//   The servo pulse width ramps between PULSE_MIN (closed) and PULSE_MAX
//   (open) by STEP cycles per PWM frame. The door dwells fully open for
//   HOLD_PERIODS frames, then closes by itself. An obstruction or a re-open
//   request while closing reverses the ramp.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   open_req       level: request door open at present_floor
//   close_req      level: request immediate close
//   obstruct       level: door path blocked
//   present_floor  current cab floor, 1-based
//   servo_pwm      one-hot PWM, bit f-1 drives the floor f servo
//   door_closed    state is CLOSED
//   door_open      state is OPEN_HOLD
//   busy           state is OPENING or CLOSING
//   req_err        1-cycle pulse: open request in CLOSED with an invalid floor
//
// Interface semantics: there is no valid/ready handshake. open_req, close_req
// and obstruct are levels sampled on every rising clk edge. Priority is
// obstruct > open_req > close_req. req_err fires once for each rising edge
// of open_req that arrives with an out-of-range floor while CLOSED.
// -----------------------------------------------------------------------------
module door_servo_ctrl #(
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_W      = 4,
  parameter int PERIOD       = 1_000_000,
  parameter int PULSE_MIN    = 100_000,
  parameter int PULSE_MAX    = 200_000,
  parameter int STEP         = 500,
  parameter int HOLD_PERIODS = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  open_req,
  input  logic                  close_req,
  input  logic                  obstruct,
  input  logic [FLOOR_W-1:0]    present_floor,
  output logic [NUM_FLOORS-1:0] servo_pwm,
  output logic                  door_closed,
  output logic                  door_open,
  output logic                  busy,
  output logic                  req_err
);

  localparam int SPAN   = PULSE_MAX - PULSE_MIN;
  localparam int OFF_W  = $clog2(SPAN + 1);
  localparam int CNT_W  = $clog2(PERIOD);
  localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  typedef enum logic [1:0] {
    ST_CLOSED    = 2'd0,
    ST_OPENING   = 2'd1,
    ST_OPEN_HOLD = 2'd2,
    ST_CLOSING   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [OFF_W-1:0]      offset_q, offset_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [FLOOR_W-1:0]    floor_l_q, floor_l_d;
  logic                  open_req_prev_q;
  logic [NUM_FLOORS-1:0] pwm_q, pwm_d;
  logic                  door_closed_q, door_open_q, busy_q;
  logic                  req_err_q, req_err_d;

  logic                  pe;
  logic                  floor_ok;
  logic                  pulse_on;
  logic [OFF_W-1:0]      off_inc, off_dec;

  // Frame end: the ramp only advances here, so a frame's pulse width is
  // always the offset that was in force when the frame started.
  assign pe       = (cnt_q == CNT_W'(PERIOD - 1));
  assign floor_ok = (present_floor != '0) && (int'(present_floor) <= NUM_FLOORS);
  assign pulse_on = (int'(cnt_q) < (PULSE_MIN + int'(offset_q)));

  // Saturating ramp arithmetic done in 32-bit so it never wraps.
  assign off_inc = ((int'(offset_q) + STEP) >= SPAN) ? OFF_W'(SPAN)
                                                     : OFF_W'(int'(offset_q) + STEP);
  assign off_dec = (int'(offset_q) <= STEP) ? '0
                                            : OFF_W'(int'(offset_q) - STEP);

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    hold_cnt_d = hold_cnt_q;
    floor_l_d  = floor_l_q;
    req_err_d  = 1'b0;
    cnt_d      = pe ? '0 : cnt_q + 1'b1;

    case (state_q)
      ST_CLOSED: begin
        if (open_req) begin
          if (floor_ok) begin
            state_d    = ST_OPENING;
            floor_l_d  = present_floor;
            offset_d   = '0;
            hold_cnt_d = '0;
            cnt_d      = '0;  // first opening frame is full length
          end else begin
            req_err_d  = !open_req_prev_q;
          end
        end
      end

      ST_OPENING: begin
        if (close_req && !obstruct && !open_req) begin
          state_d = ST_CLOSING;
        end else if (pe) begin
          offset_d = off_inc;
          if (off_inc == OFF_W'(SPAN)) begin
            state_d    = ST_OPEN_HOLD;
            hold_cnt_d = '0;
          end
        end
      end

      ST_OPEN_HOLD: begin
        if (obstruct || open_req) begin
          hold_cnt_d = '0;
        end else if (close_req) begin
          state_d = ST_CLOSING;
        end else if (pe) begin
          // hold_cnt counts completed dwell frames, so the door stays
          // open for exactly HOLD_PERIODS frames.
          if (hold_cnt_q == HOLD_W'(HOLD_PERIODS - 1)) begin
            state_d = ST_CLOSING;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end

      ST_CLOSING: begin
        if (obstruct || open_req) begin
          state_d = ST_OPENING;
        end else if (pe) begin
          offset_d = off_dec;
          if (off_dec == '0) begin
            state_d = ST_CLOSED;
          end
        end
      end

      default: state_d = ST_CLOSED;
    endcase
  end

  // Only the latched floor's line is ever driven; one clk behind cnt.
  always_comb begin
    pwm_d = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      pwm_d[f] = (state_q != ST_CLOSED) && (floor_l_q == FLOOR_W'(f + 1)) && pulse_on;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_CLOSED;
      offset_q        <= '0;
      cnt_q           <= '0;
      hold_cnt_q      <= '0;
      floor_l_q       <= '0;
      open_req_prev_q <= 1'b0;
      pwm_q           <= '0;
      door_closed_q   <= 1'b1;
      door_open_q     <= 1'b0;
      busy_q          <= 1'b0;
      req_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      offset_q        <= offset_d;
      cnt_q           <= cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      floor_l_q       <= floor_l_d;
      open_req_prev_q <= open_req;
      pwm_q           <= pwm_d;
      // Status flags track the state register edge-for-edge.
      door_closed_q   <= (state_d == ST_CLOSED);
      door_open_q     <= (state_d == ST_OPEN_HOLD);
      busy_q          <= (state_d == ST_OPENING) || (state_d == ST_CLOSING);
      req_err_q       <= req_err_d;
    end
  end

  assign servo_pwm   = pwm_q;
  assign door_closed = door_closed_q;
  assign door_open   = door_open_q;
  assign busy        = busy_q;
  assign req_err     = req_err_q;

endmodule

// File: tb/tb_door_servo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_door_servo_ctrl
//   Bench for door_servo_ctrl with small PWM numbers. A frame-level door
//   model predicts each servo pulse (floor line, width, door status); the
//   driver pushes those predictions into exp_q and a negedge monitor pops one
//   per observed pulse. Invalid-floor requests push into err_q and are
//   matched against req_err pulses.
// -----------------------------------------------------------------------------
module tb_door_servo_ctrl;

  localparam int NUM_FLOORS   = 4;
  localparam int FLOOR_W      = 4;
  localparam int PERIOD       = 100;
  localparam int PULSE_MIN    = 10;
  localparam int PULSE_MAX    = 20;
  localparam int STEP         = 5;
  localparam int HOLD_PERIODS = 2;
  localparam int SPAN         = PULSE_MAX - PULSE_MIN;
  localparam int W            = 16;

  localparam int M_CLOSED  = 0;
  localparam int M_OPENING = 1;
  localparam int M_HOLD    = 2;
  localparam int M_CLOSING = 3;

  localparam int EV_NONE      = 0;
  localparam int EV_CLOSE     = 1;
  localparam int EV_OBS       = 2;
  localparam int EV_OPEN      = 3;
  localparam int EV_CLOSE_OBS = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                  open_req      = 1'b0;
  logic                  close_req     = 1'b0;
  logic                  obstruct      = 1'b0;
  logic [FLOOR_W-1:0]    present_floor = '0;
  logic [NUM_FLOORS-1:0] servo_pwm;
  logic                  door_closed;
  logic                  door_open;
  logic                  busy;
  logic                  req_err;

  door_servo_ctrl #(
    .NUM_FLOORS  (NUM_FLOORS),
    .FLOOR_W     (FLOOR_W),
    .PERIOD      (PERIOD),
    .PULSE_MIN   (PULSE_MIN),
    .PULSE_MAX   (PULSE_MAX),
    .STEP        (STEP),
    .HOLD_PERIODS(HOLD_PERIODS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .open_req     (open_req),
    .close_req    (close_req),
    .obstruct     (obstruct),
    .present_floor(present_floor),
    .servo_pwm    (servo_pwm),
    .door_closed  (door_closed),
    .door_open    (door_open),
    .busy         (busy),
    .req_err      (req_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  int           err_q[$];

  // door model: mode, ramp offset, dwell frames done, latched floor
  int m_mode  = M_CLOSED;
  int m_off   = 0;
  int m_hold  = 0;
  int m_floor = 0;

  int run [NUM_FLOORS];

  // {status[2:0] = {door_closed, door_open, busy}, floor line, width}
  function automatic logic [W-1:0] pack_exp(input int status, input int idx, input int width);
    logic [W-1:0] v;
    v = {1'b0, status[2:0], idx[3:0], width[7:0]};
    return v;
  endfunction

  function automatic int mode_status(input int mode);
    if (mode == M_CLOSED) return 4;
    if (mode == M_HOLD)   return 2;
    return 1;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_event(input int ev);
    open_req  = (ev == EV_OPEN);
    close_req = (ev == EV_CLOSE) || (ev == EV_CLOSE_OBS);
    obstruct  = (ev == EV_OBS) || (ev == EV_CLOSE_OBS);
  endtask

  // Mid-frame request: only changes where the ramp heads next.
  task automatic model_event(input int ev);
    bit obs, opn, cls;
    obs = (ev == EV_OBS) || (ev == EV_CLOSE_OBS);
    opn = (ev == EV_OPEN);
    cls = (ev == EV_CLOSE) || (ev == EV_CLOSE_OBS);
    if (m_mode == M_OPENING) begin
      if (cls && !obs && !opn) m_mode = M_CLOSING;
    end else if (m_mode == M_HOLD) begin
      if (obs || opn) m_hold = 0;
      else if (cls)   m_mode = M_CLOSING;
    end else if (m_mode == M_CLOSING) begin
      if (obs || opn) m_mode = M_OPENING;
    end
  endtask

  // End of a frame: ramp one step, or count one dwell frame.
  task automatic model_frame_end();
    if (m_mode == M_OPENING) begin
      m_off = (m_off + STEP > SPAN) ? SPAN : m_off + STEP;
      if (m_off == SPAN) begin
        m_mode = M_HOLD;
        m_hold = 0;
      end
    end else if (m_mode == M_HOLD) begin
      m_hold++;
      if (m_hold == HOLD_PERIODS) m_mode = M_CLOSING;
    end else if (m_mode == M_CLOSING) begin
      m_off = (m_off - STEP < 0) ? 0 : m_off - STEP;
      if (m_off == 0) m_mode = M_CLOSED;
    end
  endtask

  // Opens from CLOSED (called at a negedge) and runs frames until the model
  // closes. fix_frame/fix_ev force one event; rnd adds random events;
  // abort_frame pulls reset a few cycles into that frame.
  task automatic run_session(input int floor, input int fix_frame, input int fix_ev,
                             input bit rnd, input int abort_frame);
    present_floor = FLOOR_W'(floor);
    open_req = 1'b1;
    tick(1);
    open_req = 1'b0;
    m_mode  = M_OPENING;
    m_off   = 0;
    m_hold  = 0;
    m_floor = floor;
    for (int k = 0; k < 60 && m_mode != M_CLOSED; k++) begin
      int ev;
      int ph;
      exp_q.push_back(pack_exp(mode_status(m_mode), m_floor - 1, PULSE_MIN + m_off));
      present_floor = FLOOR_W'($urandom_range(0, 7));
      if (k == abort_frame) begin
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pwm", int'(servo_pwm), 0);
        check("rst_door_closed", int'(door_closed), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_door_open", int'(door_open), 0);
        exp_q.delete();
        tick(3);
        rst_n  = 1'b1;
        m_mode = M_CLOSED;
        m_off  = 0;
        return;
      end
      ev = EV_NONE;
      if (rnd && k < 15 && $urandom_range(0, 9) < 4) ev = int'($urandom_range(1, 4));
      if (k == fix_frame) ev = fix_ev;
      ph = int'($urandom_range(30, 90));
      tick(ph);
      drive_event(ev);
      tick(1);
      drive_event(EV_NONE);
      tick(PERIOD - 1 - ph);
      model_event(ev);
      model_frame_end();
    end
  endtask

  // Idle period in CLOSED, optionally with an invalid-floor request.
  task automatic closed_gap(input bit do_err);
    int bad;
    check("closed_door_closed", int'(door_closed), 1);
    check("closed_door_open", int'(door_open), 0);
    check("closed_busy", int'(busy), 0);
    check("closed_pwm", int'(servo_pwm), 0);
    tick(int'($urandom_range(2, 20)));
    if (do_err) begin
      bad = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(NUM_FLOORS + 1, 15));
      present_floor = FLOOR_W'(bad);
      err_q.push_back(bad);
      open_req = 1'b1;
      tick(int'($urandom_range(1, 4)));
      open_req = 1'b0;
      tick(3);
      check("req_err_pending", err_q.size(), 0);
      check("err_door_closed", int'(door_closed), 1);
      check("err_pwm", int'(servo_pwm), 0);
    end
  endtask

  // monitor: measure each pulse and each req_err, pop and compare
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FLOORS; f++) run[f] = 0;
    end else begin
      if (|servo_pwm) begin
        n_checks++;
        if ($countones(servo_pwm) != 1) begin
          n_fail++;
          $display("FAIL pwm_onehot: got %b expected a single line at %0t", servo_pwm, $time);
        end
      end
      for (int f = 0; f < NUM_FLOORS; f++) begin
        if (servo_pwm[f]) begin
          run[f]++;
        end else if (run[f] > 0) begin
          logic [W-1:0] act;
          logic [W-1:0] expv;
          act = pack_exp(int'({door_closed, door_open, busy}), f, run[f]);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pwm_pulse: got unexpected pulse bit=%0d width=%0d expected none at %0t",
                     f, run[f], $time);
          end else begin
            expv = exp_q.pop_front();
            if (act != expv) begin
              n_fail++;
              $display("FAIL pwm_pulse: got status=%b bit=%0d width=%0d expected status=%b bit=%0d width=%0d at %0t",
                       act[14:12], act[11:8], act[7:0], expv[14:12], expv[11:8], expv[7:0], $time);
            end
          end
          run[f] = 0;
        end
      end
      if (req_err) begin
        n_checks++;
        if (err_q.size() == 0) begin
          n_fail++;
          $display("FAIL req_err: got unexpected pulse expected none at %0t", $time);
        end else begin
          void'(err_q.pop_front());
        end
      end
    end
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected test completion at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_pwm", int'(servo_pwm), 0);
    check("reset_door_closed", int'(door_closed), 1);
    check("reset_door_open", int'(door_open), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_req_err", int'(req_err), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // full cycle, floor 2: widths 10,15,20,20,20,15
    closed_gap(1'b0);
    run_session(2, -1, EV_NONE, 1'b0, -1);
    closed_gap(1'b1);
    // obstruction in the first closing frame reverses the ramp
    run_session(1, 4, EV_OBS, 1'b0, -1);
    closed_gap(1'b1);
    // close request in the first dwell frame
    run_session(3, 2, EV_CLOSE, 1'b0, -1);
    closed_gap(1'b0);
    // close together with obstruction keeps the door open
    run_session(4, 2, EV_CLOSE_OBS, 1'b0, -1);
    closed_gap(1'b1);

    for (int i = 0; i < 10; i++) begin
      run_session(int'($urandom_range(1, NUM_FLOORS)), -1, EV_NONE, 1'b1, -1);
      closed_gap(1'($urandom_range(0, 1)));
    end

    // asynchronous reset while a pulse is high in the second opening frame
    run_session(3, -1, EV_NONE, 1'b0, 1);
    closed_gap(1'b1);
    run_session(2, -1, EV_NONE, 1'b0, -1);
    closed_gap(1'b0);

    check("exp_q_drained", exp_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
